// File: rtl/sim_run_pkg.sv
// -----------------------------------------------------------------------------
// sim_run_pkg
//   Shared types for the CPU verification run-control block.
//   status_t    : latched termination cause reported on sim_run_ctrl.status.
//   run_state_t : top-level sequencing state (HOLD -> RUN -> (DRAIN ->) DONE).
//   is_drain_cause() : true for causes that finish through the DRAIN window.
// -----------------------------------------------------------------------------
package sim_run_pkg;

   typedef enum logic [2:0] {
      NONE    = 3'd0,
      HALT    = 3'd1,
      TIMEOUT = 3'd2,
      STALL   = 3'd3,
      MON_ERR = 3'd4,
      MEM_ERR = 3'd5
   } status_t;

   typedef enum logic [1:0] {
      HOLD,
      RUN,
      DRAIN,
      DONE
   } run_state_t;

   // Error causes let in-flight traffic settle before finishing; all others
   // finish on the very next edge.
   function automatic logic is_drain_cause(input status_t cause);
      return (cause == MON_ERR) || (cause == MEM_ERR);
   endfunction

endpackage : sim_run_pkg

// File: rtl/sim_run_ctrl_popcount.sv
// -----------------------------------------------------------------------------
// popcount
//   Purely combinational population count.
//   Ports:
//     vec_i : W-bit input vector
//     cnt_o : number of set bits in vec_i, $clog2(W+1) bits wide
// -----------------------------------------------------------------------------
module popcount #(
   parameter int W = 8
) (
   input  logic [W-1:0]           vec_i,
   output logic [$clog2(W+1)-1:0] cnt_o
);

   localparam int CW = $clog2(W + 1);

   // NOTE: combinational accumulation uses blocking '=' so each loop step sees
   // the running sum from the previous step; clocked state always uses '<='.
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < W; i++) begin
         cnt_o = cnt_o + CW'(vec_i[i]);
      end
   end

endmodule : popcount

// File: rtl/sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// sim_run_ctrl
//   Run control for the CPU verification top: sequences CPU reset, watches the
//   commit/halt channels, enforces a cycle timeout and a forward-progress
//   watchdog, drains after monitor/memory errors and reports a latched cause
//   with a one-cycle finish pulse.
//
//   Ports:
//     clk            : clock
//     rst            : asynchronous active-high reset
//     timeout_cycles : RUN-cycle budget, captured on HOLD->RUN (0 = disabled)
//     halt           : per-channel halt request from the monitor
//     commit         : per-channel commit valid
//     mon_error      : monitor error (finishes through DRAIN)
//     mem_error      : memory model error (finishes through DRAIN)
//     cpu_rst        : reset to the CPU, high while in HOLD
//     running        : high while in RUN
//     finish         : one-cycle pulse on entry to DONE
//     status         : latched termination cause (status_t)
//     cycle_count    : cycles counted in RUN and DRAIN
//     commit_count   : commits counted in RUN and DRAIN
//   All outputs are registered.
// -----------------------------------------------------------------------------
module sim_run_ctrl
   import sim_run_pkg::*;
#(
   parameter int CHANNELS     = 8,
   parameter int RST_CYCLES   = 2,
   parameter int DRAIN_CYCLES = 5,
   parameter int TIMEOUT_W    = 32,
   parameter int STALL_LIMIT  = 100000,
   parameter int CNT_W        = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [TIMEOUT_W-1:0] timeout_cycles,
   input  logic [CHANNELS-1:0]  halt,
   input  logic [CHANNELS-1:0]  commit,
   input  logic                 mon_error,
   input  logic                 mem_error,
   output logic                 cpu_rst,
   output logic                 running,
   output logic                 finish,
   output logic [2:0]           status,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     commit_count
);

   localparam int POP_W   = $clog2(CHANNELS + 1);
   localparam int HOLD_W  = $clog2(RST_CYCLES) + 1;
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;
   localparam int STALL_W = $clog2(STALL_LIMIT) + 1;
   localparam int CMP_W   = (TIMEOUT_W > CNT_W) ? TIMEOUT_W : CNT_W;

   run_state_t           state_q;
   logic [HOLD_W-1:0]    hold_cnt_q;
   logic [DRAIN_W-1:0]   drain_cnt_q;
   logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [TIMEOUT_W-1:0] tmo_q;
   logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
   logic [CNT_W-1:0]     commit_count_q, commit_count_d;
   status_t              status_q;
   logic                 cpu_rst_q, running_q, finish_q;

   logic [POP_W-1:0]     pop_cnt;
   logic                 count_en;
   logic                 timeout_hit, stall_hit;
   status_t              exit_cause;

   popcount #(.W(CHANNELS)) u_popcount (
      .vec_i (commit),
      .cnt_o (pop_cnt)
   );

   // ---------------------------------------------------------------------------
   // Next-state for counters and exit decode
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here is given a default first, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      // DRAIN counts DRAIN_CYCLES cycles; the following edge only moves the
      // block to DONE and is not itself counted.
      count_en = (state_q == RUN) ||
                 ((state_q == DRAIN) && (drain_cnt_q != DRAIN_W'(DRAIN_CYCLES)));

      cycle_count_d  = cycle_count_q;
      commit_count_d = commit_count_q;
      if (count_en) begin
         cycle_count_d  = cycle_count_q + CNT_W'(1);
         commit_count_d = commit_count_q + CNT_W'(pop_cnt);
      end

      // Stall counter saturates at the limit so it can never wrap past it.
      stall_cnt_d = stall_cnt_q;
      if ((state_q == RUN) && (STALL_LIMIT != 0)) begin
         if (|commit) begin
            stall_cnt_d = '0;
         end else if (stall_cnt_q != STALL_W'(STALL_LIMIT)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
         end
      end

      // Both limits compare against post-increment values so the triggering
      // cycle is already included in the reported counts.
      timeout_hit = (tmo_q != '0) &&
                    (CMP_W'(cycle_count_d) == CMP_W'(tmo_q));
      stall_hit   = (STALL_LIMIT != 0) &&
                    (stall_cnt_d == STALL_W'(STALL_LIMIT));

      exit_cause = NONE;
      if (|halt) begin
         exit_cause = HALT;
      end else if (timeout_hit) begin
         exit_cause = TIMEOUT;
      end else if (mon_error) begin
         exit_cause = MON_ERR;
      end else if (mem_error) begin
         exit_cause = MEM_ERR;
      end else if (stall_hit) begin
         exit_cause = STALL;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencing FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= HOLD;
         hold_cnt_q     <= '0;
         drain_cnt_q    <= '0;
         stall_cnt_q    <= '0;
         tmo_q          <= '0;
         cycle_count_q  <= '0;
         commit_count_q <= '0;
         status_q       <= NONE;
         cpu_rst_q      <= 1'b1;
         running_q      <= 1'b0;
         finish_q       <= 1'b0;
      end else begin
         finish_q       <= 1'b0;
         cycle_count_q  <= cycle_count_d;
         commit_count_q <= commit_count_d;
         stall_cnt_q    <= stall_cnt_d;

         case (state_q)
            HOLD: begin
               if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                  state_q   <= RUN;
                  cpu_rst_q <= 1'b0;
                  running_q <= 1'b1;
                  tmo_q     <= timeout_cycles;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
               end
            end

            RUN: begin
               if (exit_cause != NONE) begin
                  status_q  <= exit_cause;
                  running_q <= 1'b0;
                  if (is_drain_cause(exit_cause)) begin
                     state_q     <= DRAIN;
                     drain_cnt_q <= '0;
                  end else begin
                     state_q  <= DONE;
                     finish_q <= 1'b1;
                  end
               end
            end

            // Status is already latched; all new events are ignored here.
            DRAIN: begin
               if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES)) begin
                  state_q  <= DONE;
                  finish_q <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
               end
            end

            DONE: begin
               state_q <= DONE;
            end

            default: begin
               state_q <= HOLD;
            end
         endcase
      end
   end

   assign cpu_rst      = cpu_rst_q;
   assign running      = running_q;
   assign finish       = finish_q;
   assign status       = status_q;
   assign cycle_count  = cycle_count_q;
   assign commit_count = commit_count_q;

endmodule : sim_run_ctrl

// File: tb/tb_sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_run_ctrl
//   Scoreboard bench: each run's stimulus is laid out per RUN cycle in arrays,
//   the expected outcome is pushed to a queue, and a monitor pops and compares
//   whenever the DUT pulses finish.
// -----------------------------------------------------------------------------
module tb_sim_run_ctrl;
   import sim_run_pkg::*;

   localparam int CH     = 8;
   localparam int RSTC   = 2;
   localparam int DRAINC = 5;
   localparam int STALLL = 16;
   localparam int TW     = 32;
   localparam int CNTW   = 64;
   localparam int MAXK   = 256;
   localparam int BUDGET = 400;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [TW-1:0]   timeout_cycles = '0;
   logic [CH-1:0]   halt = '0;
   logic [CH-1:0]   commit = '0;
   logic            mon_error = 1'b0;
   logic            mem_error = 1'b0;
   logic            cpu_rst, running, finish;
   logic [2:0]      status;
   logic [CNTW-1:0] cycle_count, commit_count;

   sim_run_ctrl #(
      .CHANNELS     (CH),
      .RST_CYCLES   (RSTC),
      .DRAIN_CYCLES (DRAINC),
      .TIMEOUT_W    (TW),
      .STALL_LIMIT  (STALLL),
      .CNT_W        (CNTW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .timeout_cycles (timeout_cycles),
      .halt           (halt),
      .commit         (commit),
      .mon_error      (mon_error),
      .mem_error      (mem_error),
      .cpu_rst        (cpu_rst),
      .running        (running),
      .finish         (finish),
      .status         (status),
      .cycle_count    (cycle_count),
      .commit_count   (commit_count)
   );

   always #5 clk = ~clk;

   // Clock edges since rst was released (edge 1 is the first one).
   int edge_no;
   always @(posedge clk or posedge rst) begin
      if (rst) edge_no <= 0;
      else     edge_no <= edge_no + 1;
   end

   // Stimulus per RUN cycle k (k = 1 is the first edge sampled in RUN).
   logic [CH-1:0] halt_v   [0:MAXK+8];
   logic [CH-1:0] commit_v [0:MAXK+8];
   logic          mon_v    [0:MAXK+8];
   logic          mem_v    [0:MAXK+8];

   typedef struct {
      logic [2:0]  status;
      logic [63:0] cyc;
      logic [63:0] com;
      int          fin;   // edge_no at which finish is expected high
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;
   bit   got_finish;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic clear_vecs();
      for (int k = 0; k <= MAXK + 8; k++) begin
         halt_v[k]   = '0;
         commit_v[k] = '0;
         mon_v[k]    = 1'b0;
         mem_v[k]    = 1'b0;
      end
   endtask

   task automatic push_exp(input logic [2:0] st, input logic [63:0] cyc,
                           input logic [63:0] com, input int fin);
      exp_t e;
      e.status = st;
      e.cyc    = cyc;
      e.com    = com;
      e.fin    = fin;
      exp_q.push_back(e);
   endtask

   // Reference model: walk the RUN cycles, apply the cause priority, then add
   // the counted drain cycles for error exits.
   function automatic exp_t model(input logic [TW-1:0] tmo);
      exp_t        e;
      logic [63:0] cyc = 0;
      logic [63:0] com = 0;
      int          stall = 0;
      bit          done = 0;
      e.status = 3'(NONE);
      e.fin    = -1;
      for (int k = 1; k <= MAXK && !done; k++) begin
         cyc++;
         com += 64'($countones(commit_v[k]));
         stall = (commit_v[k] != 0) ? 0 : stall + 1;
         done = 1;
         if (halt_v[k] != 0)                 e.status = 3'(HALT);
         else if (tmo != 0 && cyc == 64'(tmo)) e.status = 3'(TIMEOUT);
         else if (mon_v[k])                  e.status = 3'(MON_ERR);
         else if (mem_v[k])                  e.status = 3'(MEM_ERR);
         else if (stall == STALLL)           e.status = 3'(STALL);
         else                                done = 0;
         if (done) begin
            if (e.status == 3'(MON_ERR) || e.status == 3'(MEM_ERR)) begin
               for (int d = 1; d <= DRAINC; d++) begin
                  cyc++;
                  com += 64'($countones(commit_v[k + d]));
               end
               e.fin = RSTC + k + DRAINC + 1;
            end else begin
               e.fin = RSTC + k;
            end
         end
      end
      e.cyc = cyc;
      e.com = com;
      return e;
   endfunction

   // Monitor: compares on every finish pulse, checks the pulse is one cycle
   // wide and the counters freeze afterwards.
   initial begin
      exp_t cur;
      bit   chk_after = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (chk_after) begin
               check("finish_width", 64'(finish), 64'd0);
               check("cycle_freeze", cycle_count, cur.cyc);
               check("commit_freeze", commit_count, cur.com);
               chk_after = 1'b0;
            end
            if (edge_no == RSTC - 1) begin
               check("hold_cpu_rst", 64'(cpu_rst), 64'd1);
               check("hold_running", 64'(running), 64'd0);
            end
            if (edge_no == RSTC) begin
               check("run_cpu_rst", 64'(cpu_rst), 64'd0);
               check("run_running", 64'(running), 64'd1);
               check("run_status", 64'(status), 64'd0);
            end
            if (finish) begin
               got_finish = 1'b1;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_finish actual=1 expected=0 (edge %0d)", edge_no);
               end else begin
                  cur = exp_q.pop_front();
                  check("status", 64'(status), 64'(cur.status));
                  check("cycle_count", cycle_count, cur.cyc);
                  check("commit_count", commit_count, cur.com);
                  check("finish_edge", 64'(edge_no), 64'(cur.fin));
                  check("running_done", 64'(running), 64'd0);
                  chk_after = 1'b1;
               end
            end
         end
      end
   end

   task automatic drive(input int k);
      if (k >= 1 && k <= MAXK + 8) begin
         halt      = halt_v[k];
         commit    = commit_v[k];
         mon_error = mon_v[k];
         mem_error = mem_v[k];
      end else begin
         halt      = '0;
         commit    = '0;
         mon_error = 1'b0;
         mem_error = 1'b0;
      end
   endtask

   // One run: async reset (checked mid-cycle), release, play the vectors until
   // finish or until abort_edge (>0) is reached.
   task automatic run_test(input logic [TW-1:0] tmo, input int abort_edge);
      bit done = 1'b0;
      @(negedge clk); #1;
      rst = 1'b1;
      drive(0);
      timeout_cycles = tmo;
      #1;
      check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("rst_running", 64'(running), 64'd0);
      check("rst_finish", 64'(finish), 64'd0);
      check("rst_status", 64'(status), 64'd0);
      check("rst_cycle_count", cycle_count, 64'd0);
      check("rst_commit_count", commit_count, 64'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      got_finish = 1'b0;
      mon_en = 1'b1;
      for (int n = 0; n < BUDGET && !done; n++) begin
         drive(edge_no + 1 - RSTC);
         @(negedge clk); #1;
         if (got_finish) done = 1'b1;
         else if (abort_edge > 0 && edge_no >= abort_edge) done = 1'b1;
      end
      if (got_finish) begin
         @(negedge clk); #1;
      end else if (abort_edge == 0) begin
         checks++;
         failures++;
         $display("FAIL finish_timeout actual=no_finish expected=finish within %0d cycles", BUDGET);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      mon_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=still_running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [TW-1:0] tmo;
      exp_t          e;
      int            dens;

      // halt[3] in RUN cycle 10
      clear_vecs();
      halt_v[10] = 8'h08;
      push_exp(3'(HALT), 64'd10, 64'd0, RSTC + 10);
      run_test(32'd0, 0);

      // timeout 50, one commit per cycle
      clear_vecs();
      for (int k = 1; k <= MAXK; k++) commit_v[k] = 8'h01;
      push_exp(3'(TIMEOUT), 64'd50, 64'd50, RSTC + 50);
      run_test(32'd50, 0);

      // mem_error at 20, halt during DRAIN ignored
      clear_vecs();
      for (int k = 1; k <= MAXK; k++) commit_v[k] = 8'h01;
      mem_v[20]  = 1'b1;
      halt_v[22] = 8'h10;
      push_exp(3'(MEM_ERR), 64'd25, 64'd25, RSTC + 20 + DRAINC + 1);
      run_test(32'd0, 0);

      // stall: 8'hFF on cycles 1..5, then nothing
      clear_vecs();
      for (int k = 1; k <= 5; k++) commit_v[k] = 8'hFF;
      push_exp(3'(STALL), 64'd21, 64'd40, RSTC + 21);
      run_test(32'd0, 0);

      // halt and mon_error together: HALT wins, no drain
      clear_vecs();
      for (int k = 1; k <= MAXK; k++) commit_v[k] = 8'h01;
      halt_v[7] = 8'h01;
      mon_v[7]  = 1'b1;
      push_exp(3'(HALT), 64'd7, 64'd7, RSTC + 7);
      run_test(32'd0, 0);

      // mon_error at 12; timeout (15) falls inside DRAIN and is ignored
      clear_vecs();
      for (int k = 1; k <= MAXK; k++) commit_v[k] = 8'h03;
      mon_v[12] = 1'b1;
      push_exp(3'(MON_ERR), 64'd17, 64'd34, RSTC + 12 + DRAINC + 1);
      run_test(32'd15, 0);

      // mon_error at 5, stop two cycles into DRAIN; next run resets mid-DRAIN
      clear_vecs();
      for (int k = 1; k <= MAXK; k++) commit_v[k] = 8'h01;
      mon_v[5] = 1'b1;
      run_test(32'd0, RSTC + 5 + 2);
      check("drain_running", 64'(running), 64'd0);
      check("drain_status", 64'(status), 64'(MON_ERR));
      check("drain_cycle_count", cycle_count, 64'd7);

      // randomized runs against the reference model
      for (int t = 0; t < 24; t++) begin
         clear_vecs();
         dens = $urandom_range(0, 4);
         for (int k = 1; k <= MAXK + 8; k++) begin
            commit_v[k] = ($urandom_range(0, 3) < dens) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 149) == 0) halt_v[k] = 8'h01 << $urandom_range(0, 7);
            mon_v[k] = ($urandom_range(0, 179) == 0);
            mem_v[k] = ($urandom_range(0, 179) == 0);
         end
         tmo = TW'($urandom_range(8, 200));
         e = model(tmo);
         exp_q.push_back(e);
         run_test(tmo, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sim_run_ctrl

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Synthesizable run-control block for the CPU verification top. It sequences CPU reset, watches all commit channels for halt and commit activity, and enforces a runtime-loaded cycle timeout and a forward-progress (stall) watchdog. On a monitor or memory error it drains for a fixed number of cycles before finishing. It reports a latched termination cause, a one-cycle `finish` pulse and 64-bit cycle/commit counters, so the bench only reacts to `finish`.

## Interface
Parameters:
- `CHANNELS`, 8: number of commit/halt channels (≥1).
- `RST_CYCLES`, 2: cycles `cpu_rst` is held high after `rst` deasserts (≥1).
- `DRAIN_CYCLES`, 5: cycles between error detection and finish (≥1).
- `TIMEOUT_W`, 32: width of `timeout_cycles`.
- `STALL_LIMIT`, 100000: consecutive commit-free RUN cycles that trigger STALL; 0 disables.
- `CNT_W`, 64: width of `cycle_count` and `commit_count`.

Ports:
- `clk`  in  1  clock; the block has one clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `timeout_cycles`  in  TIMEOUT_W  RUN-cycle budget, sampled on HOLD→RUN; 0 disables.
- `halt`  in  CHANNELS  per-channel halt from the monitor.
- `commit`  in  CHANNELS  per-channel commit valid.
- `mon_error`  in  1  monitor error.
- `mem_error`  in  1  memory model error.
- `cpu_rst`  out  1  reset to the DUT.
- `running`  out  1  high in RUN.
- `finish`  out  1  one-cycle pulse on entry to DONE.
- `status`  out  3  termination cause (`status_t`).
- `cycle_count`  out  CNT_W  cycles spent in RUN and DRAIN.
- `commit_count`  out  CNT_W  total commits in RUN and DRAIN.

## Operation
- States: HOLD → RUN → (DRAIN →) DONE. DONE is terminal until `rst`.
- HOLD: a counter runs 0..RST_CYCLES-1. The block moves to RUN after RST_CYCLES clock edges. `timeout_cycles` is captured into `tmo_q` on this transition.
- RUN: each cycle the events below are evaluated, and the highest-priority one wins.
  - any `halt` bit → DONE, status HALT (1).
  - `tmo_q`≠0 and the post-increment cycle_count equals `tmo_q` → DONE, status TIMEOUT (2).
  - `mon_error` → DRAIN, status MON_ERR (4).
  - `mem_error` → DRAIN, status MEM_ERR (5).
  - STALL_LIMIT≠0 and `stall_cnt` reaches STALL_LIMIT → DONE, status STALL (3).
- `stall_cnt` clears in any cycle with a nonzero `commit`. Otherwise it increments, saturating at STALL_LIMIT.
- DRAIN: counts DRAIN_CYCLES cycles, then goes to DONE. `halt`, errors, timeout and stall are all ignored, and status stays at the first cause.
- `cycle_count` increments by 1 in RUN and DRAIN. `commit_count` adds popcount(`commit`) in RUN and DRAIN. Both wrap modulo 2^CNT_W, and both freeze in HOLD and DONE.
- `status` is NONE (0) until the first cause is latched. The cause then holds until `rst`.

## Timing
- Reset values: state HOLD, `cpu_rst`=1, `running`=0, `finish`=0, `status`=0, counters 0, `stall_cnt`=0.
- All outputs are registered; there is no combinational input→output path.
- `cpu_rst` falls and `running` rises on the same edge that enters RUN.
- An event sampled in RUN at edge N gives `running`=0 after edge N. For HALT/TIMEOUT/STALL, `finish`=1 for exactly the cycle after edge N.
- For an error at edge N: DRAIN occupies cycles N+1..N+DRAIN_CYCLES, and `finish` pulses after edge N+DRAIN_CYCLES+1.
- The cycle that triggers an exit is still counted in `cycle_count` and `commit_count`.
- Asserting `rst` mid-run clears everything immediately, asynchronously, and the sequence restarts in HOLD.
- `halt` together with `mon_error` in the same cycle gives HALT, with no drain.

## Structure
- Package `sim_run_pkg` holds:
  - `status_t` (NONE=0, HALT=1, TIMEOUT=2, STALL=3, MON_ERR=4, MEM_ERR=5).
  - `run_state_t` (HOLD, RUN, DRAIN, DONE).
- Sub-module `popcount #(.W(CHANNELS))` is purely combinational and returns a $clog2(CHANNELS+1)-bit count.
- Counter widths are $clog2 of the corresponding parameter + 1.

## Test plan
- Reset, then `halt[3]`=1 at RUN cycle 10 → `cpu_rst` high for 2 cycles, `finish` pulse one cycle later, status=1, cycle_count=10.
- `timeout_cycles`=50 with commits every cycle and no halt → status=2, cycle_count=50, commit_count=50 when `commit`=8'h01.
- `mem_error` at RUN cycle 20 → `finish` 6 cycles later, status=5, cycle_count=25. `halt` asserted during DRAIN is ignored.
- STALL_LIMIT=16, commits stop after cycle 5 → status=3 with cycle_count=21. `commit`=8'hFF on cycles 1..5 gives commit_count=40.
- `halt[0]` and `mon_error` in the same cycle → status=1, no drain. `rst` pulsed mid-DRAIN → all outputs return to reset values within the reset cycle, then HOLD restarts.
